// File: rtl/morse_char_seq.sv
// +--------------------------------------------------------------------------+
// | morse_char_seq : character code to Morse symbol sequencer with gaps.      |
// | Optional feature macro: MORSE_WORD_GAP_EN (code 36 = word space).         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module morse_char_seq #(
  parameter int GAP_SYM  = 1,
  parameter int GAP_CHAR = 3,
  parameter int GAP_WORD = 7,
  parameter int CNT_W    = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       char_vld,
  input  logic [5:0] char_code,
  output logic       char_rdy,
  output logic       sym_strt,
  output logic       symbol,
  input  logic       sym_done,
  output logic       char_done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       len;
  logic [4:0]       pattern;
  logic [2:0]       idx;
  logic [CNT_W-1:0] count;
  logic             last;
  logic [7:0]       lut;
  logic             lut_ok;
  logic             is_word;
  logic             accept;

  // {len, pattern}; pattern bit0 is the first symbol, 1 = dash
  always_comb begin
    lut = 8'd0;
    case (char_code)
      6'd0:  lut = {3'd2, 5'b00010}; // A .-
      6'd1:  lut = {3'd4, 5'b00001}; // B -...
      6'd2:  lut = {3'd4, 5'b00101}; // C -.-.
      6'd3:  lut = {3'd3, 5'b00001}; // D -..
      6'd4:  lut = {3'd1, 5'b00000}; // E .
      6'd5:  lut = {3'd4, 5'b00100}; // F ..-.
      6'd6:  lut = {3'd3, 5'b00011}; // G --.
      6'd7:  lut = {3'd4, 5'b00000}; // H ....
      6'd8:  lut = {3'd2, 5'b00000}; // I ..
      6'd9:  lut = {3'd4, 5'b01110}; // J .---
      6'd10: lut = {3'd3, 5'b00101}; // K -.-
      6'd11: lut = {3'd4, 5'b00010}; // L .-..
      6'd12: lut = {3'd2, 5'b00011}; // M --
      6'd13: lut = {3'd2, 5'b00001}; // N -.
      6'd14: lut = {3'd3, 5'b00111}; // O ---
      6'd15: lut = {3'd4, 5'b00110}; // P .--.
      6'd16: lut = {3'd4, 5'b01011}; // Q --.-
      6'd17: lut = {3'd3, 5'b00010}; // R .-.
      6'd18: lut = {3'd3, 5'b00000}; // S ...
      6'd19: lut = {3'd1, 5'b00001}; // T -
      6'd20: lut = {3'd3, 5'b00100}; // U ..-
      6'd21: lut = {3'd4, 5'b01000}; // V ...-
      6'd22: lut = {3'd3, 5'b00110}; // W .--
      6'd23: lut = {3'd4, 5'b01001}; // X -..-
      6'd24: lut = {3'd4, 5'b01101}; // Y -.--
      6'd25: lut = {3'd4, 5'b00011}; // Z --..
      6'd26: lut = {3'd5, 5'b11111}; // 0
      6'd27: lut = {3'd5, 5'b11110}; // 1
      6'd28: lut = {3'd5, 5'b11100}; // 2
      6'd29: lut = {3'd5, 5'b11000}; // 3
      6'd30: lut = {3'd5, 5'b10000}; // 4
      6'd31: lut = {3'd5, 5'b00000}; // 5
      6'd32: lut = {3'd5, 5'b00001}; // 6
      6'd33: lut = {3'd5, 5'b00011}; // 7
      6'd34: lut = {3'd5, 5'b00111}; // 8
      6'd35: lut = {3'd5, 5'b01111}; // 9
      default: lut = 8'd0;
    endcase
  end

  assign lut_ok = (lut[7:5] != 3'd0);

`ifdef MORSE_WORD_GAP_EN
  assign is_word = (char_code == 6'd36);
`else
  logic [CNT_W-1:0] unused_gap_word;
  assign unused_gap_word = CNT_W'(GAP_WORD);
  assign is_word         = 1'b0;
`endif

  assign accept = (state == S_IDLE) && char_vld;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept && lut_ok)       state_nxt = S_ISSUE;
        else if (accept && is_word) state_nxt = S_GAP;
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (sym_done) state_nxt = S_GAP;
      S_GAP:   if (count == CNT_W'(1)) state_nxt = last ? S_DONE : S_ISSUE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      len     <= 3'd0;
      pattern <= 5'd0;
      idx     <= 3'd0;
      count   <= '0;
      last    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (lut_ok) begin
              len     <= lut[7:5];
              pattern <= lut[4:0];
              idx     <= 3'd0;
              last    <= 1'b0;
            end else if (is_word) begin
              count <= CNT_W'(GAP_WORD);
              last  <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (sym_done) begin
            if (idx == len - 3'd1) begin
              count <= CNT_W'(GAP_CHAR);
              last  <= 1'b1;
            end else begin
              idx   <= idx + 3'd1;
              count <= CNT_W'(GAP_SYM);
            end
          end
        end
        S_GAP:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign char_rdy  = (state == S_IDLE) && !reset;
  assign sym_strt  = (state == S_ISSUE);
  assign symbol    = ((state == S_ISSUE) || (state == S_WAIT)) && pattern[idx];
  assign char_done = (state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_morse_char_seq.sv
// +--------------------------------------------------------------------------+
// | tb_morse_char_seq : directed self-checking bench for morse_char_seq.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_morse_char_seq;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       char_vld = 1'b0;
  logic [5:0] char_code = 6'd0;
  logic       char_rdy;
  logic       sym_strt;
  logic       symbol;
  logic       sym_done = 1'b0;
  logic       char_done;
  logic       err;

  int errors = 0;
  int checks = 0;

  int         n_strt, strt_first, strt_last, n_done, done_cyc, n_err, err_cyc;
  int         n_rdy, hold_bad, gap_min, gap_max;
  logic [4:0] sym_bits;
  logic       rdy_end;

  morse_char_seq dut (
    .clock     (clock),
    .reset     (reset),
    .char_vld  (char_vld),
    .char_code (char_code),
    .char_rdy  (char_rdy),
    .sym_strt  (sym_strt),
    .symbol    (symbol),
    .sym_done  (sym_done),
    .char_done (char_done),
    .err       (err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Cycle 0 presents the code; a simple LED model answers each sym_strt
  // with sym_done dly0 (first symbol) or dlyn (later symbols) cycles later.
  task automatic run_char(input logic [5:0] code, input int dly0, input int dlyn,
                          input int ncyc, input bit stray, input bit hold);
    int   done_at;
    int   last_done;
    logic cur_sym;
    bit   in_sym;
    done_at = -1; last_done = -1; in_sym = 0; cur_sym = 1'b0;
    n_strt = 0; strt_first = -1; strt_last = -1; n_done = 0; done_cyc = -1;
    n_err = 0; err_cyc = -1; n_rdy = 0; hold_bad = 0; gap_min = 999; gap_max = -1;
    sym_bits = 5'd0;
    for (int c = 0; c < ncyc; c++) begin
      if (sym_strt) begin
        if (n_strt < 5) sym_bits[n_strt] = symbol;
        if (strt_first < 0) strt_first = c;
        strt_last = c;
        if (last_done >= 0) begin
          if (c - last_done < gap_min) gap_min = c - last_done;
          if (c - last_done > gap_max) gap_max = c - last_done;
        end
        done_at = c + ((n_strt == 0) ? dly0 : dlyn);
        cur_sym = symbol;
        in_sym  = 1;
        n_strt++;
      end else if (in_sym && symbol !== cur_sym) begin
        hold_bad++;
      end
      if (char_done) begin n_done++; done_cyc = c; end
      if (err) begin n_err++; err_cyc = c; end
      if (c > 0 && char_rdy) n_rdy++;
      char_vld  = (c == 0) || hold;
      char_code = (c == 0) ? code : 6'd40;
      sym_done  = (c == done_at) || (stray && (c == 0 || sym_strt));
      if (c == done_at) begin last_done = c; in_sym = 0; end
      tick();
    end
    sym_done = 1'b0;
    char_vld = 1'b0;
    rdy_end  = char_rdy;
  endtask

  task automatic check_run(input string tag, input int e_nstrt, input int e_bits,
                           input int e_first, input int e_last, input int e_done,
                           input int e_nerr, input int e_nrdy);
    chk({tag, "_nstrt"}, n_strt, e_nstrt);
    chk({tag, "_bits"}, int'(sym_bits), e_bits);
    chk({tag, "_first"}, strt_first, e_first);
    chk({tag, "_last"}, strt_last, e_last);
    chk({tag, "_ndone"}, n_done, (e_done >= 0) ? 1 : 0);
    chk({tag, "_donecyc"}, done_cyc, e_done);
    chk({tag, "_nerr"}, n_err, e_nerr);
    chk({tag, "_errcyc"}, err_cyc, (e_nerr > 0) ? 1 : -1);
    chk({tag, "_nrdy"}, n_rdy, e_nrdy);
    chk({tag, "_rdyend"}, int'(rdy_end), 1);
    chk({tag, "_hold"}, hold_bad, 0);
    if (e_nstrt > 1) begin
      chk({tag, "_gapmin"}, gap_min, 2);
      chk({tag, "_gapmax"}, gap_max, 2);
    end
  endtask

  initial begin
    int cnt_strt;
    int cnt_done;
    int cnt_err;

    // Reset values while reset is still high
    tick();
    tick();
    chk("rst_sym_strt", int'(sym_strt), 0);
    chk("rst_symbol", int'(symbol), 0);
    chk("rst_char_done", int'(char_done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_char_rdy", int'(char_rdy), 0);
    reset = 1'b0;
    #1;
    chk("rdy_after_rst", int'(char_rdy), 1);
    tick();

    // Letter A: strt 1,4; done 2,7; char_done 11; ready again at 12
    chk("A_rdy0", int'(char_rdy), 1);
    run_char(6'd0, 1, 3, 12, 0, 0);
    check_run("A", 2, 5'b00010, 1, 4, 11, 0, 0);

    // Same as A with stray sym_done in IDLE and during ISSUE, char_vld held
    run_char(6'd0, 1, 3, 12, 1, 1);
    check_run("A_stray", 2, 5'b00010, 1, 4, 11, 0, 0);

    // Digit 0: five dashes
    run_char(6'd26, 1, 1, 19, 0, 0);
    check_run("D0", 5, 5'b11111, 1, 13, 18, 0, 0);

    // Digit 7 (--...) with slower LED
    run_char(6'd33, 2, 2, 24, 0, 0);
    check_run("D7", 5, 5'b00011, 1, 17, 23, 0, 0);

    // Letter Q (--.-)
    run_char(6'd16, 1, 1, 16, 0, 0);
    check_run("Q", 4, 5'b01011, 1, 10, 15, 0, 0);

    // Letter E: single dot, shortest character
    run_char(6'd4, 2, 2, 8, 0, 0);
    check_run("E", 1, 5'b00000, 1, 1, 7, 0, 0);

    // Letter T: single dash
    run_char(6'd19, 1, 1, 7, 0, 0);
    check_run("T", 1, 5'b00001, 1, 1, 6, 0, 0);

    // Invalid codes
    run_char(6'd40, 1, 1, 4, 0, 0);
    check_run("C40", 0, 0, -1, -1, -1, 1, 3);
    run_char(6'd63, 1, 1, 4, 0, 0);
    check_run("C63", 0, 0, -1, -1, -1, 1, 3);

`ifdef MORSE_WORD_GAP_EN
    run_char(6'd36, 1, 1, 9, 0, 0);
    check_run("C36", 0, 0, -1, -1, 8, 0, 0);
`else
    run_char(6'd36, 1, 1, 4, 0, 0);
    check_run("C36", 0, 0, -1, -1, -1, 1, 3);
`endif

    // Letter B, reset while waiting on the first symbol
    run_char(6'd1, 100, 1, 3, 0, 0);
    chk("B_nstrt_pre", n_strt, 1);
    chk("B_sym_pre", int'(sym_bits[0]), 1);
    chk("B_wait_symbol", int'(symbol), 1);
    reset = 1'b1;
    tick();
    chk("B_rst_strt", int'(sym_strt), 0);
    chk("B_rst_symbol", int'(symbol), 0);
    chk("B_rst_rdy", int'(char_rdy), 0);
    reset = 1'b0;
    #1;
    chk("B_rdy_release", int'(char_rdy), 1);
    cnt_strt = 0; cnt_done = 0; cnt_err = 0;
    for (int c = 0; c < 10; c++) begin
      sym_done = (c == 0);
      tick();
      if (sym_strt) cnt_strt++;
      if (char_done) cnt_done++;
      if (err) cnt_err++;
    end
    sym_done = 1'b0;
    chk("B_post_strt", cnt_strt, 0);
    chk("B_post_done", cnt_done, 0);
    chk("B_post_err", cnt_err, 0);
    chk("B_post_rdy", int'(char_rdy), 1);

    // Block still works after the abandoned character
    run_char(6'd0, 1, 3, 12, 0, 0);
    check_run("A_after", 2, 5'b00010, 1, 4, 11, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
